// File: rtl/vga_fb_scheduler_pkg.sv
// Shared types and default display geometry for the VGA frame-buffer scheduler.
package vga_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN
    } state_e;

    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_FRAME_PIX = DEF_H_ACTIVE * DEF_V_ACTIVE;

    // Bits needed to hold a pixel index in 0..frame_pix-1.
    function automatic int unsigned idx_width(input int unsigned frame_pix);
        return (frame_pix > 1) ? $clog2(frame_pix) : 1;
    endfunction

endpackage

// File: rtl/vga_fb_scheduler_if.sv
// Display, pixel-writer and frame-buffer SRAM signals of the VGA frame-buffer scheduler.
interface vga_fb_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 24
);
    logic              frame_start;
    logic              pix_req;
    logic [DATA_W-1:0] color;
    logic              underflow;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic              sram_re;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        output frame_start, pix_req, wr_valid, wr_addr, wr_data, sram_rdata,
        input  color, underflow, wr_ready, sram_addr, sram_we, sram_re, sram_wdata
    );

    modport slave (
        input  frame_start, pix_req, wr_valid, wr_addr, wr_data, sram_rdata,
        output color, underflow, wr_ready, sram_addr, sram_we, sram_re, sram_wdata
    );
endinterface

// File: rtl/vga_fb_scheduler_pix_fifo.sv
// Synchronous show-ahead pixel FIFO with flush; head is valid whenever the FIFO is not empty.
module vga_pix_fifo #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Shares one single-port frame-buffer SRAM between VGA display prefetch and a pixel writer.
module vga_fb_scheduler
    import vga_sched_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LOW_WM     = 4,
    parameter int unsigned HIGH_WM    = 12,
    parameter int unsigned FB_BASE    = 0
) (
    input logic     i_clk,
    input logic     i_rst,
    vga_fb_if.slave bus
);

    localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int unsigned IDX_W     = idx_width(FRAME_PIX);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LVL_W     = CNT_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIX - 1);
    localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(LOW_WM);
    localparam logic [LVL_W-1:0] LVL_HIGH = LVL_W'(HIGH_WM);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              inflight_q;
    logic              underflow_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  level;
    logic              can_read;
    logic              do_read;
    logic              do_write;
    logic              push;
    logic              pop;

    // Level counts the read still in flight so the FIFO can never be over-subscribed.
    assign level    = LVL_W'(fifo_count) + LVL_W'(inflight_q);
    assign can_read = (level < LVL_FULL);
    assign push     = inflight_q & ~fifo_full;
    assign pop      = bus.pix_req & ~fifo_empty & ~i_rst;

    vga_pix_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (bus.frame_start),
        .push  (push),
        .wdata (bus.sram_rdata),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d  = state_q;
        do_read  = 1'b0;
        do_write = 1'b0;
        if (!i_rst) begin
            unique case (state_q)
                S_IDLE, S_DRAIN: begin
                    do_write = bus.wr_valid;
                end
                S_FILL: begin
                    do_read = can_read;
                    if (!can_read) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (level <= LVL_LOW) begin
                        do_read = 1'b1;
                    end else if (bus.wr_valid && level >= LVL_HIGH) begin
                        do_write = 1'b1;
                    end else if (can_read) begin
                        do_read = 1'b1;
                    end else begin
                        do_write = bus.wr_valid;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            if (do_read && idx_q == LAST_IDX) begin
                state_d = S_DRAIN;
            end
            if (bus.frame_start) begin
                state_d = S_FILL;
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (do_read && idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
        end
        if (bus.frame_start) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            inflight_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            // A read issued alongside a restart belongs to the old frame and is dropped.
            inflight_q <= do_read & ~bus.frame_start;
            if (bus.pix_req && fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.sram_addr = '0;
        if (do_write) begin
            bus.sram_addr = bus.wr_addr;
        end else if (do_read) begin
            bus.sram_addr = ADDR_W'(FB_BASE) + ADDR_W'(idx_q);
        end
    end

    assign bus.color      = pop ? fifo_head : '0;
    assign bus.underflow  = underflow_q;
    assign bus.wr_ready   = do_write;
    assign bus.sram_we    = do_write;
    assign bus.sram_re    = do_read;
    assign bus.sram_wdata = do_write ? bus.wr_data : '0;

endmodule
